// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA raster timing and frame-buffer reader with underrun tracking.
// Optional saturating underrun pixel counter is enabled by defining VGA_RD_UNDERRUN_CNT_EN.
module vga_frame_reader #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rdy_to_rd,
    input  logic [15:0] mem_dout,
    output logic        mem_rd_req,
    output logic        vga_data_lock,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb,
    output logic        rd_underrun,
    output logic [15:0] underrun_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_LOCKED = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          de_early;
    logic          hs_early;
    logic          vs_early;
    logic          last_pixel;
    logic          underrun_hit;
    logic          req_q;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // Counters never stall: there is no back-pressure path into the raster.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= VW'(V_ACTIVE);
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign de_early   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_early   = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
    assign vs_early   = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
    assign last_pixel = de_early && (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_de <= 1'b0;
        end else begin
            vga_hs <= hs_early;
            vga_vs <= vs_early;
            vga_de <= de_early;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions fire on the edge that brings the counters to (0, first back-porch line)
    // and (0, 0), so the new state is already in effect at those raster positions.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BLANK:  if (h_last && (v_cnt == VW'(VS_END - 1))) state_nxt = S_LOCKED;
            S_LOCKED: if (h_last && v_last)                      state_nxt = S_STREAM;
            S_STREAM: if (last_pixel)                            state_nxt = S_BLANK;
            default:                                             state_nxt = S_BLANK;
        endcase
    end

    always_comb begin
        vga_data_lock = (state != S_BLANK);
        mem_rd_req    = (state == S_STREAM) && de_early && mem_rdy_to_rd;
        underrun_hit  = (state == S_STREAM) && de_early && !mem_rdy_to_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= 1'b0;
            rd_underrun <= 1'b0;
        end else begin
            req_q <= mem_rd_req;
            if (underrun_hit) begin
                rd_underrun <= 1'b1;
            end
        end
    end

    // Read data lands one cycle after the request, aligned with the registered vga_de.
    assign vga_rgb = (vga_de && req_q) ? mem_dout : 16'h0000;

`ifdef VGA_RD_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= 16'h0000;
        end else if (underrun_hit && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`else
    assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed self-checking bench for vga_frame_reader.
module tb_vga_frame_reader;

    logic        clk;
    logic        rst;
    logic        mem_rdy_to_rd;
    logic [15:0] mem_dout;
    logic        mem_rd_req;
    logic        vga_data_lock;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [15:0] vga_rgb;
    logic        rd_underrun;
    logic [15:0] underrun_cnt;

    int tests;
    int fails;
    int th;
    int tv;
    int exp_base;
    logic        mem_req_seen;
    logic [15:0] req_cnt;

    vga_frame_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rdy_to_rd(mem_rdy_to_rd),
        .mem_dout     (mem_dout),
        .mem_rd_req   (mem_rd_req),
        .vga_data_lock(vga_data_lock),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_de       (vga_de),
        .vga_rgb      (vga_rgb),
        .rd_underrun  (rd_underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference raster position: 14 clocks per line, 8 lines per frame, reset to (0,4).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            th = 0;
            tv = 4;
        end else if (th == 13) begin
            th = 0;
            tv = (tv == 7) ? 0 : tv + 1;
        end else begin
            th = th + 1;
        end
    end

    // Memory model: returns the running request index one cycle after each request.
    always @(negedge clk) begin
        #2;
        mem_req_seen = mem_rd_req;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            req_cnt  = 16'd0;
            mem_dout = 16'hBEEF;
        end else if (mem_req_seen) begin
            mem_dout = req_cnt;
            req_cnt  = req_cnt + 16'd1;
        end else begin
            mem_dout = 16'hBEEF;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        mem_rdy_to_rd = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (mem_rd_req !== 1'b0)       begin fails++; $display("FAIL reset_req: got %b want 0", mem_rd_req); end
        tests++; if (vga_data_lock !== 1'b0)    begin fails++; $display("FAIL reset_lock: got %b want 0", vga_data_lock); end
        tests++; if (vga_hs !== 1'b1)           begin fails++; $display("FAIL reset_hs: got %b want 1", vga_hs); end
        tests++; if (vga_vs !== 1'b1)           begin fails++; $display("FAIL reset_vs: got %b want 1", vga_vs); end
        tests++; if (vga_de !== 1'b0)           begin fails++; $display("FAIL reset_de: got %b want 0", vga_de); end
        tests++; if (vga_rgb !== 16'h0000)      begin fails++; $display("FAIL reset_rgb: got %h want 0000", vga_rgb); end
        tests++; if (rd_underrun !== 1'b0)      begin fails++; $display("FAIL reset_underrun: got %b want 0", rd_underrun); end
        tests++; if (underrun_cnt !== 16'h0000) begin fails++; $display("FAIL reset_ucnt: got %h want 0000", underrun_cnt); end
    endtask

    task automatic test_stream();
        int n;
        int req_seen;
        logic p_req, p_hs, p_vs, e_req, e_lock;
        logic [15:0] idx, p_idx, e_rgb;
        mem_rdy_to_rd = 1'b1;
        rst = 1'b0;
        n = 0;
        while (vga_data_lock !== 1'b1 && n < 200) begin
            tests++; if (mem_rd_req !== 1'b0) begin fails++; $display("FAIL blank_req: got %b want 0 at h=%0d v=%0d", mem_rd_req, th, tv); end
            @(negedge clk); n++;
        end
        tests++; if (vga_data_lock !== 1'b1 || th != 0 || tv != 6) begin fails++; $display("FAIL lock_rise: lock=%b at h=%0d v=%0d want 1 at h=0 v=6", vga_data_lock, th, tv); end
        n = 0;
        while (!(th == 0 && tv == 0) && n < 200) begin
            tests++; if (mem_rd_req !== 1'b0) begin fails++; $display("FAIL locked_req: got %b want 0 at h=%0d v=%0d", mem_rd_req, th, tv); end
            @(negedge clk); n++;
        end
        tests++; if (!(th == 0 && tv == 0)) begin fails++; $display("FAIL frame_start_timeout: at h=%0d v=%0d want h=0 v=0", th, tv); end
        tests++; if (mem_rd_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", mem_rd_req); end
        p_req = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        idx = exp_base[15:0]; p_idx = idx; req_seen = 0;
        for (int c = 0; c < 112; c++) begin
            e_req  = (th < 8) && (tv < 4);
            e_lock = (tv < 3) || (tv == 3 && th < 8) || (tv >= 6);
            e_rgb  = p_req ? p_idx : 16'h0000;
            tests++; if (mem_rd_req !== e_req)       begin fails++; $display("FAIL stream_req: got %b want %b at h=%0d v=%0d", mem_rd_req, e_req, th, tv); end
            tests++; if (vga_data_lock !== e_lock)   begin fails++; $display("FAIL stream_lock: got %b want %b at h=%0d v=%0d", vga_data_lock, e_lock, th, tv); end
            tests++; if (vga_de !== p_req)           begin fails++; $display("FAIL stream_de: got %b want %b at h=%0d v=%0d", vga_de, p_req, th, tv); end
            tests++; if (vga_hs !== p_hs)            begin fails++; $display("FAIL stream_hs: got %b want %b at h=%0d v=%0d", vga_hs, p_hs, th, tv); end
            tests++; if (vga_vs !== p_vs)            begin fails++; $display("FAIL stream_vs: got %b want %b at h=%0d v=%0d", vga_vs, p_vs, th, tv); end
            tests++; if (vga_rgb !== e_rgb)          begin fails++; $display("FAIL stream_rgb: got %h want %h at h=%0d v=%0d", vga_rgb, e_rgb, th, tv); end
            if (mem_rd_req === 1'b1) req_seen++;
            p_idx = idx;
            if (e_req) idx = idx + 16'd1;
            p_req = e_req;
            p_hs  = !(th >= 10 && th < 12);
            p_vs  = (tv != 5);
            @(negedge clk);
        end
        tests++; if (req_seen != 32) begin fails++; $display("FAIL stream_req_count: got %0d want 32", req_seen); end
        exp_base += 32;
    endtask

    task automatic test_timing();
        int hs_low, vs_low;
        logic e_hs, e_vs;
        hs_low = 0; vs_low = 0;
        mem_rdy_to_rd = 1'b1;
        for (int c = 0; c < 112; c++) begin
            e_hs = !(th == 11 || th == 12);
            e_vs = !((tv == 5 && th != 0) || (tv == 6 && th == 0));
            tests++; if (vga_hs !== e_hs) begin fails++; $display("FAIL timing_hs: got %b want %b at h=%0d v=%0d", vga_hs, e_hs, th, tv); end
            tests++; if (vga_vs !== e_vs) begin fails++; $display("FAIL timing_vs: got %b want %b at h=%0d v=%0d", vga_vs, e_vs, th, tv); end
            if (vga_hs === 1'b0) hs_low++;
            if (vga_vs === 1'b0) vs_low++;
            @(negedge clk);
        end
        tests++; if (hs_low != 16) begin fails++; $display("FAIL timing_hs_count: got %0d want 16", hs_low); end
        tests++; if (vs_low != 14) begin fails++; $display("FAIL timing_vs_count: got %0d want 14", vs_low); end
        exp_base += 32;
    endtask

    task automatic test_underrun();
        int req_seen;
        logic p_req, p_de, e_req, e_de;
        logic [15:0] idx, p_idx, e_rgb, e_cnt;
        tests++; if (rd_underrun !== 1'b0) begin fails++; $display("FAIL underrun_pre: got %b want 0", rd_underrun); end
        p_req = 1'b0; p_de = 1'b0; idx = exp_base[15:0]; p_idx = idx; req_seen = 0;
        for (int c = 0; c < 112; c++) begin
            mem_rdy_to_rd = !(tv == 2 && th >= 5 && th <= 7);
            #1;
            e_de  = (th < 8) && (tv < 4);
            e_req = e_de && mem_rdy_to_rd;
            e_rgb = p_req ? p_idx : 16'h0000;
            tests++; if (mem_rd_req !== e_req) begin fails++; $display("FAIL underrun_req: got %b want %b at h=%0d v=%0d", mem_rd_req, e_req, th, tv); end
            tests++; if (vga_de !== p_de)      begin fails++; $display("FAIL underrun_de: got %b want %b at h=%0d v=%0d", vga_de, p_de, th, tv); end
            tests++; if (vga_rgb !== e_rgb)    begin fails++; $display("FAIL underrun_rgb: got %h want %h at h=%0d v=%0d", vga_rgb, e_rgb, th, tv); end
            if (mem_rd_req === 1'b1) req_seen++;
            p_idx = idx;
            if (e_req) idx = idx + 16'd1;
            p_req = e_req;
            p_de  = e_de;
            @(negedge clk);
        end
        mem_rdy_to_rd = 1'b1;
`ifdef VGA_RD_UNDERRUN_CNT_EN
        e_cnt = 16'd3;
`else
        e_cnt = 16'd0;
`endif
        tests++; if (req_seen != 29)         begin fails++; $display("FAIL underrun_req_count: got %0d want 29", req_seen); end
        tests++; if (rd_underrun !== 1'b1)   begin fails++; $display("FAIL underrun_flag: got %b want 1", rd_underrun); end
        tests++; if (underrun_cnt !== e_cnt) begin fails++; $display("FAIL underrun_cnt: got %0d want %0d", underrun_cnt, e_cnt); end
        exp_base += 29;
    endtask

    task automatic test_midframe_reset();
        int n;
        mem_rdy_to_rd = 1'b1;
        n = 0;
        while (!(th == 3 && tv == 1) && n < 50) begin
            @(negedge clk); n++;
        end
        tests++; if (mem_rd_req !== 1'b1 || vga_data_lock !== 1'b1) begin fails++; $display("FAIL mid_pre: req=%b lock=%b at h=%0d v=%0d want 1 1 at h=3 v=1", mem_rd_req, vga_data_lock, th, tv); end
        rst = 1'b1;
        #1;
        tests++; if (mem_rd_req !== 1'b0)       begin fails++; $display("FAIL mid_req: got %b want 0", mem_rd_req); end
        tests++; if (vga_data_lock !== 1'b0)    begin fails++; $display("FAIL mid_lock: got %b want 0", vga_data_lock); end
        tests++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_de !== 1'b0) begin fails++; $display("FAIL mid_sync: got hs=%b vs=%b de=%b want 1 1 0", vga_hs, vga_vs, vga_de); end
        tests++; if (vga_rgb !== 16'h0000)      begin fails++; $display("FAIL mid_rgb: got %h want 0000", vga_rgb); end
        tests++; if (rd_underrun !== 1'b0)      begin fails++; $display("FAIL mid_underrun: got %b want 0", rd_underrun); end
        tests++; if (underrun_cnt !== 16'h0000) begin fails++; $display("FAIL mid_ucnt: got %h want 0000", underrun_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (vga_data_lock !== 1'b1 && n < 200) begin
            tests++; if (mem_rd_req !== 1'b0) begin fails++; $display("FAIL mid_blank_req: got %b want 0", mem_rd_req); end
            @(negedge clk); n++;
        end
        tests++; if (n != 28 || th != 0 || tv != 6) begin fails++; $display("FAIL mid_relock: after %0d clocks at h=%0d v=%0d want 28 at h=0 v=6", n, th, tv); end
        n = 0;
        while (!(th == 0 && tv == 0) && n < 200) begin
            @(negedge clk); n++;
        end
        tests++; if (mem_rd_req !== 1'b1 || n != 28) begin fails++; $display("FAIL mid_restream: req=%b after %0d clocks want 1 after 28", mem_rd_req, n); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_base = 0;
        rst = 1'b1;
        mem_rdy_to_rd = 1'b0;
        test_reset();
        test_stream();
        test_timing();
        test_underrun();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
